// File: rtl/mux_ser_pkg.sv
// Shared definitions for the 8-bit mux-based serializer.
package mux_ser_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Select index that starts a word for the given bit order.
  function automatic logic [SEL_W-1:0] first_sel(input logic msb_first);
    return msb_first ? '1 : '0;
  endfunction

  // Select index that ends a word for the given bit order.
  function automatic logic [SEL_W-1:0] last_sel(input logic msb_first);
    return msb_first ? '0 : '1;
  endfunction

  // One step along the word in the given bit order (3-bit wrap never reached).
  function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] cur,
                                                input logic msb_first);
    return msb_first ? (cur - SEL_W'(1)) : (cur + SEL_W'(1));
  endfunction

endpackage

// File: rtl/mux_8x1.sv
// 8-to-1 single-bit multiplexer: Y = I[S].
module mux_8x1 (
  input  logic [7:0] I,
  input  logic [2:0] S,
  output logic       Y
);

  // Pick the selected bit of the input word.
  always_comb begin
    Y = 1'b0;
    case (S)
      3'd0: Y = I[0];
      3'd1: Y = I[1];
      3'd2: Y = I[2];
      3'd3: Y = I[3];
      3'd4: Y = I[4];
      3'd5: Y = I[5];
      3'd6: Y = I[6];
      3'd7: Y = I[7];
      default: Y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_serializer_8.sv
// Parallel-to-serial converter: holds an accepted byte and walks a mux
// select across it, one bit per downstream handshake.
module mux_serializer_8
  import mux_ser_pkg::*;
#(
  parameter logic MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       ser_last,
  output logic [2:0] sel,
  output logic [7:0] word
);

  localparam logic [SEL_W-1:0] FIRST_SEL = first_sel(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST_SEL  = last_sel(MSB_FIRST);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_q,  word_d;
  logic [SEL_W-1:0]    sel_q,   sel_d;
  logic                live_q,  live_d;
  logic                xfer;

  // in_ready stays low through reset and only opens on the first edge after
  // release, hence the separate live_q flag rather than decoding IDLE alone.
  always_comb begin
    ser_valid = (state_q == SHIFT);
    ser_last  = ser_valid && (sel_q == LAST_SEL);
    in_ready  = live_q && ((state_q == IDLE) || (ser_last && out_ready));
    xfer      = in_valid && in_ready;
  end

  // Next-state: load on transfer, advance on consumed bit, drop to IDLE after last.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    live_d  = 1'b1;
    if (xfer) begin
      word_d  = in_data;
      sel_d   = FIRST_SEL;
      state_d = SHIFT;
    end else if ((state_q == SHIFT) && out_ready) begin
      if (ser_last) begin
        state_d = IDLE;
      end else begin
        sel_d = step_sel(sel_q, MSB_FIRST);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      live_q  <= live_d;
    end
  end

  mux_8x1 u_mux (
    .I (word_q),
    .S (sel_q),
    .Y (ser_out)
  );

  assign sel  = sel_q;
  assign word = word_q;

endmodule

// File: tb/tb_mux_serializer_8.sv
// Bench for mux_serializer_8: instance 0 is LSB-first, instance 1 MSB-first.
module tb_mux_serializer_8;

  logic       clk;
  logic       rst_n;
  logic       iv     [2];
  logic [7:0] id     [2];
  logic       ordy   [2];
  logic       rdy    [2];
  logic       so     [2];
  logic       sv     [2];
  logic       sl     [2];
  logic [2:0] sel_o  [2];
  logic [7:0] word_o [2];

  int n_checks = 0;
  int n_pass   = 0;

  mux_serializer_8 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(id[0]),
    .in_ready(rdy[0]), .out_ready(ordy[0]), .ser_out(so[0]),
    .ser_valid(sv[0]), .ser_last(sl[0]), .sel(sel_o[0]), .word(word_o[0])
  );

  mux_serializer_8 #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(id[1]),
    .in_ready(rdy[1]), .out_ready(ordy[1]), .ser_out(so[1]),
    .ser_valid(sv[1]), .ser_last(sl[1]), .sel(sel_o[1]), .word(word_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: a word is 8 bits to hand out; m_cnt counts bits already
  // consumed, and the select index is just that count in the chosen bit order.
  logic [7:0]  m_word [2];
  logic [2:0]  m_sel  [2];
  int unsigned m_cnt  [2];
  bit          m_busy [2];
  bit          m_live [2];

  function automatic logic [2:0] sel_of(input int i, input int unsigned c);
    return (i == 1) ? 3'(7 - c) : 3'(c);
  endfunction

  function automatic logic exp_rdy(input int i);
    return m_live[i] && (!m_busy[i] || (m_cnt[i] == 7 && ordy[i]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_word[i] = '0; m_sel[i] = '0; m_cnt[i] = 0; m_busy[i] = 0; m_live[i] = 0;
    end
  endtask

  initial begin
    bit xf;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        for (int i = 0; i < 2; i++) begin
          xf = iv[i] && exp_rdy(i);
          if (m_busy[i] && ordy[i]) begin
            if (m_cnt[i] == 7) m_busy[i] = 0;
            else m_cnt[i]++;
          end
          if (xf) begin
            m_word[i] = id[i];
            m_cnt[i]  = 0;
            m_busy[i] = 1;
          end
          if (m_busy[i]) m_sel[i] = sel_of(i, m_cnt[i]);
          m_live[i] = 1;
        end
      end
    end
  end

  // Every falling edge: all outputs of both instances against the model.
  initial begin
    logic [7:0] w;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        w = m_word[i];
        check($sformatf("m%0d_valid", i), sv[i],     m_busy[i]);
        check($sformatf("m%0d_last", i),  sl[i],     m_busy[i] && m_cnt[i] == 7);
        check($sformatf("m%0d_ready", i), rdy[i],    exp_rdy(i));
        check($sformatf("m%0d_sel", i),   sel_o[i],  m_sel[i]);
        check($sformatf("m%0d_word", i),  word_o[i], m_word[i]);
        check($sformatf("m%0d_out", i),   so[i],     w[m_sel[i]]);
      end
    end
  end

  task automatic test_lsb_aa();
    int exp_bits [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    @(posedge clk); #1 iv[0] = 1; id[0] = 8'b10101010; ordy[0] = 1;
    @(posedge clk); #1 iv[0] = 0; id[0] = 8'h55;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("a_bit",  so[0], exp_bits[k]);
      check("a_last", sl[0], k == 7);
      check("a_word", word_o[0], 8'hAA);
      if (k == 3) #1 id[0] = 8'h00;
    end
    @(negedge clk);
    check("a_idle", sv[0], 0);
  endtask

  task automatic test_msb_f0();
    int exp_bits [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    @(posedge clk); #1 iv[1] = 1; id[1] = 8'b11110000; ordy[1] = 1;
    @(posedge clk); #1 iv[1] = 0; id[1] = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b_bit",  so[1], exp_bits[k]);
      check("b_sel",  sel_o[1], 7 - k);
      check("b_last", sl[1], k == 7);
    end
    @(negedge clk);
    check("b_idle", sv[1], 0);
  endtask

  task automatic test_b2b();
    logic [15:0] stream;
    stream = {8'h0F, 8'hA5};
    @(posedge clk); #1 iv[0] = 1; id[0] = 8'hA5; ordy[0] = 1;
    @(posedge clk); #1 id[0] = 8'h0F;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("c_valid", sv[0], 1);
      check("c_ready", rdy[0], (k == 7) || (k == 15));
      check("c_bit",   so[0], stream[k]);
      if (k == 8) #1 iv[0] = 0;
    end
    @(negedge clk);
    check("c_idle", sv[0], 0);
  endtask

  task automatic test_stall();
    @(posedge clk); #1 iv[0] = 1; id[0] = 8'b00001111; ordy[0] = 1;
    @(posedge clk); #1 iv[0] = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("d_sel", sel_o[0], k);
    end
    #1 ordy[0] = 0;
    repeat (3) begin
      @(negedge clk);
      check("d_hold_sel", sel_o[0], 3);
      check("d_hold_out", so[0], 1);
      check("d_hold_vld", sv[0], 1);
    end
    #1 ordy[0] = 1;
    @(negedge clk);
    check("d_resume_sel", sel_o[0], 4);
    check("d_resume_out", so[0], 0);
    repeat (4) @(negedge clk);
    check("d_idle", sv[0], 0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 iv[0] = 1; id[0] = 8'h3C; ordy[0] = 1;
    @(posedge clk); #1 iv[0] = 0;
    for (int k = 0; k < 6; k++) @(negedge clk);
    check("e_sel5", sel_o[0], 5);
    check("e_out5", so[0], 1);
    #1 rst_n = 0;
    #1;
    check("e_rst_valid", sv[0], 0);
    check("e_rst_last",  sl[0], 0);
    check("e_rst_out",   so[0], 0);
    check("e_rst_sel",   sel_o[0], 0);
    check("e_rst_word",  word_o[0], 0);
    check("e_rst_ready", rdy[0], 0);
    @(negedge clk); #1 rst_n = 1;
    #1 check("e_rel_ready0", rdy[0], 0);
    @(negedge clk);
    check("e_rel_ready1", rdy[0], 1);
    check("e_rel_valid",  sv[0], 0);
  endtask

  initial begin
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; id[i] = '0; ordy[i] = 1;
    end
    repeat (3) @(negedge clk);
    check("r_word", word_o[0], 0);
    check("r_ready", rdy[1], 0);
    #1 rst_n = 1;
    #1 check("r_ready_pre_edge", rdy[0], 0);
    @(negedge clk);
    check("r_ready_up0", rdy[0], 1);
    check("r_ready_up1", rdy[1], 1);

    test_lsb_aa();
    test_msb_f0();
    test_b2b();
    test_stall();
    test_reset_mid();

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        iv[i]   = ($urandom_range(0, 99) < 60);
        id[i]   = 8'($urandom);
        ordy[i] = ($urandom_range(0, 99) < 70);
      end
      if (c == 1500) begin
        rst_n = 0;
        #2 rst_n = 1;
      end
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
